// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / next-PC controller for the multi-cycle MIPS core.
//
// Holds the PC, runs the imem req/ack handshake, latches the fetched word for
// decode, and on ex_done picks the next PC (halt > jr > jump > branch > seq).
// Also counts retired instructions.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   imem_req/addr         fetch request (held until ack), address = pc
//   imem_ack/rdata        one-cycle ack pulse with the instruction word
//   instr, instr_valid    latched instruction, valid for the whole of EXEC
//   ex_done               execute finished; decision inputs valid this cycle
//   br_taken, br_offset   conditional branch, unshifted sign-extended offset
//   jump, j_index         J/JAL target field
//   jr, jr_addr           JR/JALR register target
//   halt                  stop after this instruction
//   pc, pc_plus4          current PC and its link value
//   retire_cnt            retired-instruction count, wraps at 2^32
//   halted                sequencer parked in HALT until reset
//   align_err             one-cycle pulse on a misaligned jr (trap build only)
//
// Build option
//   PC_ALIGN_TRAP_EN  misaligned jr traps to EXC_VEC and pulses align_err.
//                     Undefined: the low two target bits are dropped silently.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] j_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt,
  output logic        halted,
  output logic        align_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

`ifdef PC_ALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        align_q, align_d;

  logic [31:0] br_target, j_target, jr_target;
  logic        misalign;

  assign pc_plus4  = pc_q + 32'd4;
  // Branch offset is a word offset; bits above [29] fall off with the shift.
  assign br_target = pc_plus4 + {br_offset[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], j_index, 2'b00};
  assign jr_target = {jr_addr[31:2], 2'b00};
  assign misalign  = TRAP_EN && (jr_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 32'd0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    align_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
          if (halt) begin
            // Halt still retires and advances the PC.
            pc_d    = pc_plus4;
            state_d = S_HALT;
          end else if (jr) begin
            if (misalign) begin
              pc_d    = EXC_VEC;
              align_d = 1'b1;
            end else begin
              pc_d = jr_target;
            end
          end else if (jump) begin
            pc_d = j_target;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded straight from state so reset drops imem_req without waiting a clock.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign pc          = pc_q;
  assign retire_cnt  = cnt_q;
  assign align_err   = align_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: drives on the falling edge, samples on the
// falling edge (mid-cycle), expected values worked out by hand below.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done, br_taken, jump, jr, halt;
  logic [31:0] br_offset, jr_addr;
  logic [25:0] j_index;
  logic [31:0] pc, pc_plus4, retire_cnt;
  logic        halted, align_err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .ex_done(ex_done), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .j_index(j_index), .jr(jr), .jr_addr(jr_addr), .halt(halt),
    .pc(pc), .pc_plus4(pc_plus4), .retire_cnt(retire_cnt),
    .halted(halted), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // From FETCH: one-cycle ack with the given word; ends in EXEC.
  task automatic do_fetch(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  // From EXEC: one-cycle ex_done with the given decision inputs.
  task automatic do_exec(input logic b, input logic [31:0] off, input logic j,
                         input logic [25:0] idx, input logic r, input logic [31:0] ra,
                         input logic h);
    ex_done = 1'b1; br_taken = b; br_offset = off; jump = j; j_index = idx;
    jr = r; jr_addr = ra; halt = h;
    tick();
    ex_done = 1'b0; br_taken = 1'b0; br_offset = 32'd0; jump = 1'b0;
    j_index = 26'd0; jr = 1'b0; jr_addr = 32'd0; halt = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic step_seq();
    do_fetch(32'h0000_0000);
    do_exec(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    ex_done = 1'b0; br_taken = 1'b0; br_offset = 32'd0; jump = 1'b0;
    j_index = 26'd0; jr = 1'b0; jr_addr = 32'd0; halt = 1'b0;
    exp_cnt = 32'd0;

    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);

    // 1: IDLE one cycle, then fetch with ack two cycles after req
    tick(); rst_n = 1'b1;
    tick();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0000_3000);
    chk("t1_ivalid_fetch", {31'd0, instr_valid}, 32'd0);
    tick();
    do_fetch(32'h2408_0005);
    chk("t1_instr", instr, 32'h2408_0005);
    chk("t1_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("t1_req_exec", {31'd0, imem_req}, 32'd0);
    chk("t1_plus4", pc_plus4, 32'h0000_3004);
    tick();  // EXEC holds without ex_done
    chk("t1_exec_hold", {31'd0, instr_valid}, 32'd1);
    do_exec(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    chk("t1_pc", pc, 32'h0000_3004);
    chk("t1_cnt", retire_cnt, 32'd1);
    chk("t1_req_next", {31'd0, imem_req}, 32'd1);
    chk("t1_addr_next", imem_addr, 32'h0000_3004);

    // 2: branches backward and forward from 0x3010
    step_seq(); step_seq(); step_seq();
    chk("t2_pc_pre", pc, 32'h0000_3010);
    do_fetch(32'h1000_FFFF);
    do_exec(1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    chk("t2_br_back", pc, 32'h0000_3004);
    step_seq(); step_seq(); step_seq();
    do_fetch(32'h1000_0003);
    do_exec(1'b1, 32'h0000_0003, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    chk("t2_br_fwd", pc, 32'h0000_3020);

    // 3: jr back to 0x3000, jump beats branch, jr beats jump
    do_fetch(32'h0);
    do_exec(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_3000, 1'b0);
    chk("t3_jr3000", pc, 32'h0000_3000);
    do_fetch(32'h0);
    do_exec(1'b1, 32'h0000_0100, 1'b1, 26'h000_0C10, 1'b0, 32'd0, 1'b0);
    chk("t3_jump_wins", pc, 32'h0000_3040);
    do_fetch(32'h0);
    do_exec(1'b1, 32'h0000_0100, 1'b1, 26'h000_0C10, 1'b1, 32'h0000_3100, 1'b0);
    chk("t3_jr_wins", pc, 32'h0000_3100);
    chk("t3_cnt", retire_cnt, exp_cnt);

    // 4: misaligned jr
    do_fetch(32'h0);
    do_exec(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_3102, 1'b0);
`ifdef PC_ALIGN_TRAP_EN
    chk("t4_pc", pc, 32'h0000_4180);
    chk("t4_align_hi", {31'd0, align_err}, 32'd1);
    exp_pc = 32'h0000_4180;
`else
    chk("t4_pc", pc, 32'h0000_3100);
    chk("t4_align_hi", {31'd0, align_err}, 32'd0);
    exp_pc = 32'h0000_3100;
`endif
    chk("t4_cnt", retire_cnt, exp_cnt);
    chk("t4_state_fetch", {31'd0, imem_req}, 32'd1);

    // ex_done/jump while in FETCH are ignored
    ex_done = 1'b1; jump = 1'b1; j_index = 26'h3FF_FFFF;
    tick();
    ex_done = 1'b0; jump = 1'b0; j_index = 26'd0;
    chk("t4_align_lo", {31'd0, align_err}, 32'd0);
    chk("fetch_ign_pc", pc, exp_pc);
    chk("fetch_ign_cnt", retire_cnt, exp_cnt);

    // 6b: stray ack in EXEC does not overwrite instr
    do_fetch(32'hA5A5_0001);
    imem_ack = 1'b1; imem_rdata = 32'h5A5A_0002;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_instr", instr, 32'hA5A5_0001);
    chk("stray_ack_ivalid", {31'd0, instr_valid}, 32'd1);

    // 6c: counter wraps from all-ones to zero
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    do_exec(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    exp_pc = exp_pc + 32'd4;
    chk("wrap_cnt", retire_cnt, 32'd0);
    chk("wrap_pc", pc, exp_pc);

    // 5: halt beats jump, PC still advances, then everything is ignored
    do_fetch(32'h0);
    do_exec(1'b0, 32'd0, 1'b1, 26'h000_0C10, 1'b0, 32'd0, 1'b1);
    exp_pc = exp_pc + 32'd4;
    chk("t5_pc", pc, exp_pc);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_req", {31'd0, imem_req}, 32'd0);
    chk("t5_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("t5_cnt", retire_cnt, 32'd1);
    imem_ack = 1'b1; ex_done = 1'b1; jump = 1'b1; jr = 1'b1; jr_addr = 32'h0000_5000;
    tick(); tick(); tick();
    imem_ack = 1'b0; ex_done = 1'b0; jump = 1'b0; jr = 1'b0; jr_addr = 32'd0;
    chk("t5_hold_pc", pc, exp_pc);
    chk("t5_hold_cnt", retire_cnt, 32'd1);
    chk("t5_hold_halted", {31'd0, halted}, 32'd1);

    // 6a: reset from HALT, then async reset mid-fetch
    rst_n = 1'b0;
    #1;
    chk("t6_halt_rst", {31'd0, halted}, 32'd0);
    tick(); rst_n = 1'b1;
    tick();
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, 32'h0000_3000);
    exp_cnt = 32'd0;
    step_seq();
    chk("t6_pc", pc, 32'h0000_3004);
    chk("t6_cnt", retire_cnt, 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", {31'd0, imem_req}, 32'd0);
    chk("t6_pc_rst", pc, 32'h0000_3000);
    chk("t6_cnt_rst", retire_cnt, 32'd0);
    tick(); rst_n = 1'b1;
    tick();
    chk("t6_refetch", imem_addr, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
